// File: rtl/current_adc_reader.sv
// Current-sense ADC reader: timer-driven simultaneous SPI conversion on
// DATA_COUNT channels, results presented as one packed word {x0, x1, ...}.
// Latency: result appears SCLK_DIV*(2*ADC_BITS+2) clk cycles after cs_n falls.
// Backpressure: a result arriving while out_valid & ~out_ready is dropped and
// flagged on the sticky overrun bit; the held word stays stable.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   adc_sclk, adc_cs_n  shared SPI clock (CPOL=0) and chip select
//   adc_miso            one serial data line per channel, bit i = channel i
//   out_data/valid/ready  valid/ready sample stream, x0 in the MSBs, signed
//   overrun, clear_overrun  sticky drop flag and its synchronous clear
//   adc_offset          per-channel signed offset (only with CURRENT_ADC_OFFSET_EN)
//
// Build option: define CURRENT_ADC_OFFSET_EN to add the adc_offset port and a
// saturating per-channel offset subtraction; latency is identical either way.
// DATA_WIDTH must equal ADC_BITS; SAMPLE_DIV >= SCLK_DIV*(2*ADC_BITS+2)+2.

module current_adc_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_COUNT = 2,
    parameter int ADC_BITS   = 16,
    parameter int SAMPLE_DIV = 2000,
    parameter int SCLK_DIV   = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    output logic                             adc_sclk,
    output logic                             adc_cs_n,
    input  logic [DATA_COUNT-1:0]            adc_miso,
    output logic [DATA_COUNT*DATA_WIDTH-1:0] out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             overrun,
    input  logic                             clear_overrun
`ifdef CURRENT_ADC_OFFSET_EN
    ,
    input  logic [DATA_COUNT*DATA_WIDTH-1:0] adc_offset
`endif
);

    localparam int TIMER_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W   = $clog2(SCLK_DIV + 1);
    localparam int BIT_W   = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Sample-period timer: free running, independent of the FSM
    // ------------------------------------------------------------------
    logic [TIMER_W-1:0] timer;
    logic               tick;

    assign tick = (timer == TIMER_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;       // cycles within the current half-period
    logic [BIT_W-1:0] bit_cnt, bit_nxt;   // sclk period index within SHIFT
    logic             sclk_nxt;
    logic             cs_n_nxt;
    logic             sample_en;          // clk edge that raises sclk
    logic             done;               // clk edge that raises cs_n
    logic             half_done;

    assign half_done = (cnt == CNT_W'(SCLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            adc_sclk <= 1'b0;
            adc_cs_n <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_cnt  <= bit_nxt;
            adc_sclk <= sclk_nxt;
            adc_cs_n <= cs_n_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_cnt;
        sclk_nxt  = adc_sclk;
        cs_n_nxt  = adc_cs_n;
        sample_en = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                // A tick seen in any other state is simply not looked at.
                if (tick) begin
                    state_nxt = SETUP;
                    cs_n_nxt  = 1'b0;
                    cnt_nxt   = '0;
                end
            end

            SETUP: begin
                if (half_done) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            SHIFT: begin
                // sclk itself tells which half of the period we are in.
                if (half_done) begin
                    cnt_nxt = '0;
                    if (!adc_sclk) begin
                        sclk_nxt  = 1'b1;
                        sample_en = 1'b1;
                    end else begin
                        sclk_nxt = 1'b0;
                        if (bit_cnt == BIT_W'(ADC_BITS - 1)) begin
                            state_nxt = HOLD;
                        end else begin
                            bit_nxt = bit_cnt + 1'b1;
                        end
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            HOLD: begin
                if (half_done) begin
                    state_nxt = IDLE;
                    cs_n_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    done      = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                sclk_nxt  = 1'b0;
                cs_n_nxt  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-channel shift registers and code conversion
    // ------------------------------------------------------------------
    logic [ADC_BITS-1:0]              shreg [DATA_COUNT];
    logic [DATA_COUNT*DATA_WIDTH-1:0] result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DATA_COUNT; i++) begin
                shreg[i] <= '0;
            end
        end else if (sample_en) begin
            for (int i = 0; i < DATA_COUNT; i++) begin
                shreg[i] <= {shreg[i][ADC_BITS-2:0], adc_miso[i]};
            end
        end
    end

    for (genvar g = 0; g < DATA_COUNT; g++) begin : g_ch
        // Offset binary to two's complement: flip the MSB.
        logic signed [DATA_WIDTH-1:0] conv;
        assign conv = {~shreg[g][ADC_BITS-1], shreg[g][ADC_BITS-2:0]};

`ifdef CURRENT_ADC_OFFSET_EN
        localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

        logic [DATA_WIDTH-1:0] off;
        logic [DATA_WIDTH:0]   diff;
        logic [DATA_WIDTH-1:0] y;

        assign off  = adc_offset[(DATA_COUNT-1-g)*DATA_WIDTH +: DATA_WIDTH];
        // One extra bit holds every difference of two DATA_WIDTH values exactly;
        // the top two bits disagree only when the result leaves the output range.
        assign diff = {conv[DATA_WIDTH-1], conv} - {off[DATA_WIDTH-1], off};

        always_comb begin
            y = diff[DATA_WIDTH-1:0];
            if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1]) begin
                y = diff[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
            end
        end

        assign result[(DATA_COUNT-1-g)*DATA_WIDTH +: DATA_WIDTH] = y;
`else
        assign result[(DATA_COUNT-1-g)*DATA_WIDTH +: DATA_WIDTH] = conv;
`endif
    end

    // ------------------------------------------------------------------
    // Output register and overrun flag
    // ------------------------------------------------------------------
    logic load;
    logic drop;

    // An accept on the result cycle frees the register for the new set.
    assign load = done & (~out_valid | out_ready);
    assign drop = done & out_valid & ~out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= result;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A drop on the same cycle as clear_overrun keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_current_adc_reader.sv
`timescale 1ns/1ps
module tb_current_adc_reader;

    localparam int DW    = 16;
    localparam int DC    = 2;
    localparam int SDIV  = 200;
    localparam int SCDIV = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           adc_sclk;
    logic           adc_cs_n;
    logic [DC-1:0]  adc_miso;
    logic [DC*DW-1:0] out_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           overrun;
    logic           clear_overrun = 1'b0;
    logic [DC*DW-1:0] adc_offset = '0;

    always #5 clk = ~clk;

    current_adc_reader #(
        .DATA_WIDTH(DW), .DATA_COUNT(DC), .ADC_BITS(16),
        .SAMPLE_DIV(SDIV), .SCLK_DIV(SCDIV)
    ) dut (
        .clk(clk), .reset(reset),
        .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .adc_miso(adc_miso),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .clear_overrun(clear_overrun)
`ifdef CURRENT_ADC_OFFSET_EN
        , .adc_offset(adc_offset)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- ADC model: one code per channel per conversion -----
    logic [15:0] cur_code [DC];
    int          drv_idx = 16;
    logic [15:0] force_q [$];   // directed codes, ch0 then ch1
    logic [15:0] code_q  [$];   // codes issued, consumed when the result is due

    initial begin
        for (int i = 0; i < DC; i++) cur_code[i] = '0;
        forever begin
            @(negedge adc_cs_n or posedge adc_sclk);
            if (adc_sclk === 1'b1) begin
                drv_idx++;
            end else begin
                drv_idx = 0;
                for (int i = 0; i < DC; i++)
                    cur_code[i] = (force_q.size() != 0) ? force_q.pop_front() : 16'($urandom);
                for (int i = 0; i < DC; i++) code_q.push_back(cur_code[i]);
            end
        end
    end

    always_comb begin
        adc_miso = '0;
        for (int i = 0; i < DC; i++)
            if (drv_idx < 16) adc_miso[i] = cur_code[i][15-drv_idx];
    end

    // ---------------- reference model -------------------------------------
    int off0 = 0;
    int off1 = 0;

    function automatic logic [15:0] ref_sample(input logic [15:0] code, input int off);
        int v;
        v = int'(code) - 32768 - off;
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    // Edge counter since reset release: after edge j (0-based) it reads j+1.
    int ecount = 0;
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) ecount = 0;
        else       ecount++;
    end

    // ---------------- scoreboard / monitor (negedge) ----------------------
    logic [31:0] exp_q [$];
    logic        m_ov = 1'b0;
    logic        rdy_applied = 1'b0, clr_applied = 1'b0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_valid = 1'b0;
    int          rises_seen = 0, results = 0, n_acc = 0;
    int          first_fall_idx = -1, first_valid_idx = -1;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            exp_q.delete();
            code_q.delete();
            m_ov = 1'b0;
            rises_seen = 0;
            first_fall_idx = -1;
            first_valid_idx = -1;
        end else begin
            logic        drop;
            logic [15:0] c0, c1;
            logic [31:0] e;
            drop = 1'b0;
            if (prev_cs === 1'b0 && adc_cs_n === 1'b1) begin
                check("sclk_rises", rises_seen, 16);
                rises_seen = 0;
                results++;
                c0 = (code_q.size() != 0) ? code_q.pop_front() : 16'h0;
                c1 = (code_q.size() != 0) ? code_q.pop_front() : 16'h0;
                if (exp_q.size() != 0) begin
                    drop = 1'b1;
                    m_ov = 1'b1;
                end else begin
                    exp_q.push_back({ref_sample(c0, off0), ref_sample(c1, off1)});
                end
            end
            if (!drop && clr_applied) m_ov = 1'b0;
            if (prev_sclk === 1'b0 && adc_sclk === 1'b1 && adc_cs_n === 1'b0) rises_seen++;
            if (prev_cs === 1'b1 && adc_cs_n === 1'b0 && first_fall_idx < 0) first_fall_idx = ecount - 1;
            if (prev_valid !== 1'b1 && out_valid === 1'b1 && first_valid_idx < 0) first_valid_idx = ecount - 1;
            check("out_valid", out_valid, exp_q.size() != 0);
            check("overrun", overrun, m_ov);
            if (out_valid === 1'b1 && out_ready === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_data", out_data, e);
                n_acc++;
            end
        end
        rdy_applied = out_ready;
        clr_applied = clear_overrun;
        prev_cs    = adc_cs_n;
        prev_sclk  = adc_sclk;
        prev_valid = out_valid;
    end

    // ---------------- helpers ---------------------------------------------
    task automatic wait_results(input int n, input int budget);
        int target;
        target = results + n;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (results >= target) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL wait_results: got %0d results, expected %0d", results, target);
    endtask

    task automatic wait_cs_fall(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (adc_cs_n === 1'b0) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL wait_cs_fall: cs_n stayed %b, expected 0", adc_cs_n);
    endtask

    task automatic drive(input logic rdy, input logic clr);
        @(posedge clk); #1;
        out_ready = rdy;
        clear_overrun = clr;
    endtask

    // ---------------- stimulus --------------------------------------------
    initial begin
        logic [31:0] e6;
        int acc0;
        bit stall;

        repeat (3) @(negedge clk);
        check("rst_cs_n", adc_cs_n, 1'b1);
        check("rst_sclk", adc_sclk, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 32'h0);
        check("rst_overrun", overrun, 1'b0);

        // 1: first conversion, timing and code conversion
        force_q.push_back(16'h8000);
        force_q.push_back(16'h7FFF);
        out_ready = 1'b1;
        @(negedge clk); #1 reset = 1'b0;
        wait_results(1, 400);
        check("t1_fall_cycle", first_fall_idx, SDIV - 1);
        check("t1_valid_cycle", first_valid_idx, SDIV - 1 + 68);
        check("t1_data", out_data, 32'h0000_FFFF);

        // 2: continuous accept over five periods
        acc0 = n_acc;
        wait_results(5, 1100);
        check("t2_accepts", n_acc - acc0, 5);

        // 3: backpressure across two results, then clear and accept
        force_q.push_back(16'h9000); force_q.push_back(16'($urandom));
        force_q.push_back(16'hA000); force_q.push_back(16'($urandom));
        drive(1'b0, 1'b0);
        wait_results(2, 500);
        check("t3_overrun_set", overrun, 1'b1);
        check("t3_held_ch0", out_data[31:16], 16'h1000);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        @(negedge clk);
        check("t3_overrun_clr", overrun, 1'b0);
        check("t3_accept_ch0", out_data[31:16], 16'h1000);
        drive(1'b1, 1'b0);
        repeat (2) @(negedge clk);

        // 4: accept on the exact result cycle
        drive(1'b0, 1'b0);
        wait_results(1, 300);
        wait_cs_fall(300);
        repeat (67) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        check("t4_valid", out_valid, 1'b1);
        check("t4_overrun", overrun, 1'b0);

        // 5: reset in the middle of SHIFT
        wait_cs_fall(300);
        for (int i = 0; i < 200 && rises_seen < 8; i++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #3 reset = 1'b1;
        #1;
        check("t5_cs_n", adc_cs_n, 1'b1);
        check("t5_sclk", adc_sclk, 1'b0);
        check("t5_valid", out_valid, 1'b0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 400 && first_fall_idx < 0; i++) begin
            @(negedge clk); #1;
        end
        check("t5_fall_cycle", first_fall_idx, SDIV - 1);
        drive(1'b1, 1'b0);

`ifdef CURRENT_ADC_OFFSET_EN
        // 6: offset subtraction with saturation
        wait_results(1, 300);
        off0 = 100; off1 = -100;
        adc_offset = {16'(100), 16'(-100)};
        force_q.push_back(16'h8000);
        force_q.push_back(16'hFFFF);
        wait_results(1, 300);
        e6 = 32'hFF9C_7FFF;
        check("t6_offset", out_data, e6);
        off0 = int'($urandom_range(0, 4000)) - 2000;
        off1 = int'($urandom_range(0, 4000)) - 2000;
        adc_offset = {16'(off0), 16'(off1)};
`else
        e6 = 32'h0;
`endif

        // random phase: bursts of stall, random ready, sparse clears
        stall = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 40 == 0) stall = ($urandom_range(0, 2) == 0);
            drive(stall ? 1'b0 : 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
        end
        drive(1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
